// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-requester memory arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_LS = 1'b1
  } owner_e;

  localparam logic [1:0] SIZE_BYTE  = 2'b00;
  localparam logic [1:0] SIZE_HALF  = 2'b01;
  localparam logic [1:0] SIZE_WORD  = 2'b10;
  localparam logic [1:0] SIZE_DWORD = 2'b11;

  localparam logic [63:0] MASK_BYTE  = 64'h0000_0000_0000_00FF;
  localparam logic [63:0] MASK_HALF  = 64'h0000_0000_0000_FFFF;
  localparam logic [63:0] MASK_WORD  = 64'h0000_0000_FFFF_FFFF;
  localparam logic [63:0] MASK_DWORD = 64'hFFFF_FFFF_FFFF_FFFF;

  function automatic logic [63:0] size_mask(input logic [1:0] size);
    logic [63:0] m;
    case (size)
      SIZE_BYTE: m = MASK_BYTE;
      SIZE_HALF: m = MASK_HALF;
      SIZE_WORD: m = MASK_WORD;
      default:   m = MASK_DWORD;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/mem_rr_arb.sv
// Two-input grant logic: round-robin or fixed LS-over-IF priority.
module mem_rr_arb
  import mem_arb_pkg::*;
#(
  parameter int unsigned RR_EN = 1
) (
  input  logic clock,
  input  logic reset,
  input  logic if_valid,
  input  logic ls_valid,
  input  logic update,
  output logic grant_if,
  output logic grant_ls
);

  owner_e last_grant;

  always_ff @(posedge clock) begin
    if (!reset) begin
      last_grant <= OWN_IF;
    end else if (update) begin
      last_grant <= grant_ls ? OWN_LS : OWN_IF;
    end
  end

  always_comb begin
    grant_if = 1'b0;
    grant_ls = 1'b0;
    if (if_valid && ls_valid) begin
      if (RR_EN != 0) begin
        grant_ls = (last_grant == OWN_IF);
      end else begin
        grant_ls = 1'b1;
      end
      grant_if = !grant_ls;
    end else begin
      grant_if = if_valid;
      grant_ls = ls_valid;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates instruction-fetch and load-store requests onto one
// single-cycle memory port; one transaction in flight at a time.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned XLEN  = 64,
  parameter int unsigned RR_EN = 1
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            if_req_valid,
  output logic            if_req_ready,
  input  logic [XLEN-1:0] if_req_addr,
  output logic            if_resp_valid,
  input  logic            if_resp_ready,
  output logic [XLEN-1:0] if_resp_data,
  input  logic            ls_req_valid,
  output logic            ls_req_ready,
  input  logic [XLEN-1:0] ls_req_addr,
  input  logic            ls_req_wen,
  input  logic [XLEN-1:0] ls_req_wdata,
  input  logic [1:0]      ls_req_size,
  input  logic            ls_req_signed,
  output logic            ls_resp_valid,
  input  logic            ls_resp_ready,
  output logic [XLEN-1:0] ls_resp_data,
  output logic            mem_en,
  output logic            mem_w_en,
  output logic            mem_signed_en,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_w_data,
  output logic [XLEN-1:0] mem_r_mask,
  input  logic [XLEN-1:0] mem_r_data
);

  arb_state_e      state, state_n;
  owner_e          lat_owner;
  logic [XLEN-1:0] lat_addr;
  logic [XLEN-1:0] lat_wdata;
  logic [XLEN-1:0] resp_data;
  logic            lat_wen;
  logic            lat_signed;
  logic [1:0]      lat_size;
  logic            grant_if, grant_ls;
  logic            idle, if_hs, ls_hs, req_hs;

  // Outputs are qualified by reset so nothing is presented while reset is low.
  assign idle         = reset && (state == ST_IDLE);
  assign if_req_ready = idle && grant_if;
  assign ls_req_ready = idle && grant_ls;
  assign if_hs        = if_req_valid && if_req_ready;
  assign ls_hs        = ls_req_valid && ls_req_ready;
  assign req_hs       = if_hs || ls_hs;

  assign if_resp_data = resp_data;
  assign ls_resp_data = resp_data;

  mem_rr_arb #(
    .RR_EN(RR_EN)
  ) u_arb (
    .clock    (clock),
    .reset    (reset),
    .if_valid (if_req_valid),
    .ls_valid (ls_req_valid),
    .update   (req_hs),
    .grant_if (grant_if),
    .grant_ls (grant_ls)
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      state      <= ST_IDLE;
      lat_owner  <= OWN_IF;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      lat_wen    <= 1'b0;
      lat_signed <= 1'b0;
      lat_size   <= '0;
      resp_data  <= '0;
    end else begin
      state <= state_n;
      if (ls_hs) begin
        lat_owner  <= OWN_LS;
        lat_addr   <= ls_req_addr;
        lat_wdata  <= ls_req_wdata;
        lat_wen    <= ls_req_wen;
        lat_signed <= ls_req_signed;
        lat_size   <= ls_req_size;
      end else if (if_hs) begin
        lat_owner  <= OWN_IF;
        lat_addr   <= if_req_addr;
        lat_wdata  <= '0;
        lat_wen    <= 1'b0;
        lat_signed <= 1'b0;
        lat_size   <= SIZE_WORD;
      end
      if (state == ST_ISSUE) begin
        resp_data <= lat_wen ? '0 : mem_r_data;
      end
    end
  end

  always_comb begin
    state_n       = state;
    mem_en        = 1'b0;
    mem_w_en      = 1'b0;
    mem_signed_en = 1'b0;
    mem_addr      = '0;
    mem_w_data    = '0;
    mem_r_mask    = '0;
    if_resp_valid = 1'b0;
    ls_resp_valid = 1'b0;
    case (state)
      ST_IDLE: begin
        if (req_hs) state_n = ST_ISSUE;
      end
      ST_ISSUE: begin
        state_n = ST_RESP;
        if (reset) begin
          mem_en        = 1'b1;
          mem_w_en      = lat_wen;
          mem_signed_en = lat_signed && !lat_wen;
          mem_addr      = lat_addr;
          mem_w_data    = lat_wdata;
          mem_r_mask    = (lat_size == SIZE_DWORD) ? '1 : XLEN'(size_mask(lat_size));
        end
      end
      ST_RESP: begin
        if_resp_valid = reset && (lat_owner == OWN_IF);
        ls_resp_valid = reset && (lat_owner == OWN_LS);
        if ((lat_owner == OWN_IF && if_resp_ready) ||
            (lat_owner == OWN_LS && ls_resp_ready)) begin
          state_n = ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

endmodule
